// File: rtl/climate_sequencer_pkg.sv
// Shared types and constants for the climate sequencer.
// State encoding, keypad field ids, BCD limit and mode values.
package climate_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_COMPARE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam logic [1:0] FID_TENS  = 2'd0;
    localparam logic [1:0] FID_UNITS = 2'd1;
    localparam logic [1:0] FID_MOTOR = 2'd2;
    localparam logic [1:0] FID_PRES  = 2'd3;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [3:0] MOTOR_OFF     = 4'd0;
    localparam logic [3:0] MOTOR_AUTO    = 4'd1;
    localparam logic [3:0] PRES_IGNORE   = 4'd0;
    localparam logic [3:0] PRES_REQUIRED = 4'd1;

    // Two BCD digits (each already checked <= 9) to a binary value <= 99.
    function automatic logic [6:0] bcd_to_bin(
        input logic [3:0] tens,
        input logic [3:0] units
    );
        return ({3'b000, tens} * 7'd10) + {3'b000, units};
    endfunction

endpackage

// File: rtl/climate_sequencer_cfg_shadow_regs.sv
// Shadow/active configuration registers with commit validation.
// Emits registered cfg_ok/cfg_err pulses alongside the active-set update.
module cfg_shadow_regs
    import climate_sequencer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_field_valid,
    input  logic [1:0] i_field_id,
    input  logic [3:0] i_field_data,
    input  logic       i_commit,
    output logic       o_accept,
    output logic [6:0] o_setpoint,
    output logic       o_active,
    output logic       o_cfg_ok,
    output logic       o_cfg_err,
    output logic       o_auto,
    output logic       o_pres_req,
    output logic       o_next_auto,
    output logic       o_next_pres_req
);

    logic [3:0] r_sh_tens;
    logic [3:0] r_sh_units;
    logic [3:0] r_sh_motor;
    logic [3:0] r_sh_pres;
    logic [6:0] r_setpoint;
    logic       r_active;
    logic       r_cfg_ok;
    logic       r_cfg_err;
    logic       r_auto;
    logic       r_pres_req;
    logic       w_valid;
    logic       w_accept;

    // Validation sees the shadow contents before any same-cycle field write.
    assign w_valid = (r_sh_tens <= BCD_MAX) && (r_sh_units <= BCD_MAX)
                  && (r_sh_motor <= MOTOR_AUTO) && (r_sh_pres <= PRES_REQUIRED);
    assign w_accept = i_commit && w_valid;

    // Capture parsed fields; last write to an id wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_tens  <= '0;
            r_sh_units <= '0;
            r_sh_motor <= '0;
            r_sh_pres  <= '0;
        end else if (i_field_valid) begin
            unique case (i_field_id)
                FID_TENS:  r_sh_tens  <= i_field_data;
                FID_UNITS: r_sh_units <= i_field_data;
                FID_MOTOR: r_sh_motor <= i_field_data;
                FID_PRES:  r_sh_pres  <= i_field_data;
            endcase
        end
    end

    // Promote a validated shadow set and pulse the commit result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_setpoint <= '0;
            r_active   <= 1'b0;
            r_cfg_ok   <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_auto     <= 1'b0;
            r_pres_req <= 1'b0;
        end else begin
            r_cfg_ok  <= w_accept;
            r_cfg_err <= i_commit && !w_valid;
            if (w_accept) begin
                r_setpoint <= bcd_to_bin(r_sh_tens, r_sh_units);
                r_active   <= 1'b1;
                r_auto     <= (r_sh_motor == MOTOR_AUTO);
                r_pres_req <= (r_sh_pres == PRES_REQUIRED);
            end
        end
    end

    assign o_accept        = w_accept;
    assign o_setpoint      = r_setpoint;
    assign o_active        = r_active;
    assign o_cfg_ok        = r_cfg_ok;
    assign o_cfg_err       = r_cfg_err;
    assign o_auto          = r_auto;
    assign o_pres_req      = r_pres_req;
    assign o_next_auto     = w_accept ? (r_sh_motor == MOTOR_AUTO) : r_auto;
    assign o_next_pres_req = w_accept ? (r_sh_pres == PRES_REQUIRED) : r_pres_req;

endmodule

// File: rtl/climate_sequencer.sv
// Fan/motor sequencer: sample divider, ADC request FSM, hysteresis
// compare and minimum on-time hold, with shut-off overrides.
module climate_sequencer
    import climate_sequencer_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV  = 1000,
    parameter int unsigned ADC_TIMEOUT = 255,
    parameter int unsigned MIN_ON      = 500,
    parameter int unsigned HYST        = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_field_valid,
    input  logic [1:0] i_field_id,
    input  logic [3:0] i_field_data,
    input  logic       i_commit,
    input  logic [6:0] i_adc_data,
    input  logic       i_adc_ack,
    input  logic       i_presence_in,
    output logic       o_adc_req,
    output logic       o_motor_on,
    output logic [6:0] o_setpoint,
    output logic       o_cfg_ok,
    output logic       o_cfg_err,
    output logic       o_timeout_err,
    output logic       o_active
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int TO_W  = $clog2(ADC_TIMEOUT + 1);
    localparam int ON_W  = $clog2(MIN_ON + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ADC_TIMEOUT - 1);
    localparam logic [ON_W-1:0]  ON_LOAD  = ON_W'(MIN_ON);
    localparam logic [7:0]       HYST_8   = 8'(HYST);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_adc_req;
    logic              w_req_nxt;
    logic              r_motor_on;
    logic              w_motor_nxt;
    logic [6:0]        r_temp;
    logic [6:0]        w_temp_nxt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [TO_W-1:0]   w_to_nxt;
    logic [ON_W-1:0]   r_hold_cnt;
    logic [ON_W-1:0]   w_hold_nxt;
    logic [DIV_W-1:0]  r_div;
    logic              r_timeout_err;
    logic              w_to_set;
    logic              w_tick;
    logic              w_accept;
    logic [6:0]        w_setpoint;
    logic              w_active;
    logic              w_auto;
    logic              w_pres_req;
    logic              w_next_auto;
    logic              w_next_pres_req;
    logic              w_permit;
    logic              w_force_off;
    logic [7:0]        w_thresh;
    logic              w_temp_hi;
    logic              w_temp_lo;

    cfg_shadow_regs u_cfg (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_field_valid   (i_field_valid),
        .i_field_id      (i_field_id),
        .i_field_data    (i_field_data),
        .i_commit        (i_commit),
        .o_accept        (w_accept),
        .o_setpoint      (w_setpoint),
        .o_active        (w_active),
        .o_cfg_ok        (o_cfg_ok),
        .o_cfg_err       (o_cfg_err),
        .o_auto          (w_auto),
        .o_pres_req      (w_pres_req),
        .o_next_auto     (w_next_auto),
        .o_next_pres_req (w_next_pres_req)
    );

    assign w_tick      = w_active && (r_div == DIV_LAST);
    assign w_thresh    = {1'b0, w_setpoint} + HYST_8;
    assign w_temp_hi   = ({1'b0, r_temp} >= w_thresh);
    assign w_temp_lo   = (r_temp < w_setpoint);
    assign w_permit    = w_auto && (!w_pres_req || i_presence_in);
    // Uses the post-commit mode so a same-cycle accepted commit takes effect.
    assign w_force_off = !w_next_auto || (w_next_pres_req && !i_presence_in);

    // Free-running sample divider once a configuration is active.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
        end else if (!w_active || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Sticky timeout flag; a timeout in the same cycle wins over a clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timeout_err <= 1'b0;
        end else if (w_to_set) begin
            r_timeout_err <= 1'b1;
        end else if (w_accept) begin
            r_timeout_err <= 1'b0;
        end
    end

    // FSM and datapath state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_adc_req  <= 1'b0;
            r_motor_on <= 1'b0;
            r_temp     <= '0;
            r_to_cnt   <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_adc_req  <= w_req_nxt;
            r_motor_on <= w_motor_nxt;
            r_temp     <= w_temp_nxt;
            r_to_cnt   <= w_to_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Next-state logic: request, compare, hold, then shut-off overrides.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_adc_req;
        w_motor_nxt = r_motor_on;
        w_temp_nxt  = r_temp;
        w_to_nxt    = r_to_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_to_set    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = ST_REQ;
                    w_req_nxt   = 1'b1;
                    w_to_nxt    = '0;
                end
            end
            ST_REQ: begin
                if (i_adc_ack) begin
                    w_temp_nxt  = i_adc_data;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_COMPARE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_req_nxt   = 1'b0;
                    w_to_set    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + 1'b1;
                end
            end
            ST_COMPARE: begin
                w_state_nxt = ST_IDLE;
                if (w_temp_hi && w_permit) begin
                    w_motor_nxt = 1'b1;
                    w_hold_nxt  = ON_LOAD;
                    w_state_nxt = ST_HOLD;
                end else if (w_temp_lo || !w_permit) begin
                    w_motor_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hold_nxt = r_hold_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_force_off) begin
            w_motor_nxt = 1'b0;
            if (w_state_nxt == ST_HOLD) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    assign o_adc_req     = r_adc_req;
    assign o_motor_on    = r_motor_on;
    assign o_setpoint    = w_setpoint;
    assign o_timeout_err = r_timeout_err;
    assign o_active      = w_active;

endmodule

// File: tb/tb_climate_sequencer.sv
// Directed bench for climate_sequencer with an expected-result queue.
// Small parameters keep sample periods and hold times short.
module tb_climate_sequencer;

    localparam int SD = 40;
    localparam int TO = 8;
    localparam int MO = 10;
    localparam int HY = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       field_valid = 1'b0;
    logic [1:0] field_id = '0;
    logic [3:0] field_data = '0;
    logic       commit = 1'b0;
    logic [6:0] adc_data = '0;
    logic       adc_ack = 1'b0;
    logic       presence = 1'b1;
    logic       adc_req;
    logic       motor_on;
    logic [6:0] setpoint;
    logic       cfg_ok;
    logic       cfg_err;
    logic       timeout_err;
    logic       active;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];

    climate_sequencer #(
        .SAMPLE_DIV  (SD),
        .ADC_TIMEOUT (TO),
        .MIN_ON      (MO),
        .HYST        (HY)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_field_valid (field_valid),
        .i_field_id    (field_id),
        .i_field_data  (field_data),
        .i_commit      (commit),
        .i_adc_data    (adc_data),
        .i_adc_ack     (adc_ack),
        .i_presence_in (presence),
        .o_adc_req     (adc_req),
        .o_motor_on    (motor_on),
        .o_setpoint    (setpoint),
        .o_cfg_ok      (cfg_ok),
        .o_cfg_err     (cfg_err),
        .o_timeout_err (timeout_err),
        .o_active      (active)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [15:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL sb_empty: observed 0x%0h expected queued entry", obs);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    function automatic logic [15:0] all_outs();
        return 16'({adc_req, motor_on, cfg_ok, cfg_err,
                    timeout_err, active, setpoint});
    endfunction

    task automatic write_field(input logic [1:0] id, input logic [3:0] d);
        field_valid = 1'b1;
        field_id    = id;
        field_data  = d;
        step();
        field_valid = 1'b0;
    endtask

    task automatic do_commit(input string tag, input bit ok,
                             input logic [6:0] sp, input bit fv,
                             input logic [1:0] fid, input logic [3:0] fd);
        push(tag, {6'b0, ok, !ok, 1'b1, sp});
        commit      = 1'b1;
        field_valid = fv;
        field_id    = fid;
        field_data  = fd;
        step();
        commit      = 1'b0;
        field_valid = 1'b0;
        pop_check({6'b0, cfg_ok, cfg_err, active, setpoint});
        step();
        check({tag, "_pulse"}, 16'({cfg_ok, cfg_err}), 16'd0);
    endtask

    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (!adc_req && k < 4 * SD) begin
            step();
            k++;
        end
        check(tag, 16'(adc_req), 16'd1);
    endtask

    task automatic adc_sample(input string tag, input logic [6:0] temp,
                              input bit expm);
        wait_req({tag, "_req"});
        push(tag, 16'(expm));
        adc_ack  = 1'b1;
        adc_data = temp;
        step();
        adc_ack = 1'b0;
        check({tag, "_req_drop"}, 16'(adc_req), 16'd0);
        step();
        pop_check(16'(motor_on));
    endtask

    initial begin
        int cnt;
        bit held;

        step();
        check("reset_outs", all_outs(), 16'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_outs", all_outs(), 16'd0);

        write_field(2'd0, 4'd2);
        write_field(2'd1, 4'd5);
        write_field(2'd2, 4'd1);
        write_field(2'd3, 4'd0);
        do_commit("cfg_25", 1'b1, 7'd25, 1'b0, 2'd0, 4'd0);

        write_field(2'd0, 4'd12);
        do_commit("cfg_tens12", 1'b0, 7'd25, 1'b0, 2'd0, 4'd0);

        write_field(2'd0, 4'd9);
        write_field(2'd1, 4'd9);
        do_commit("cfg_99", 1'b1, 7'd99, 1'b0, 2'd0, 4'd0);

        write_field(2'd2, 4'd2);
        do_commit("cfg_motor2", 1'b0, 7'd99, 1'b0, 2'd0, 4'd0);

        write_field(2'd2, 4'd1);
        write_field(2'd0, 4'd2);
        write_field(2'd1, 4'd5);
        do_commit("cfg_same_cycle", 1'b1, 7'd25, 1'b1, 2'd0, 4'd3);
        do_commit("cfg_35", 1'b1, 7'd35, 1'b0, 2'd0, 4'd0);
        write_field(2'd0, 4'd2);
        do_commit("cfg_back25", 1'b1, 7'd25, 1'b0, 2'd0, 4'd0);

        adc_sample("hyst_25_off", 7'd25, 1'b0);
        adc_sample("hyst_26_on", 7'd26, 1'b1);
        held = 1'b1;
        for (int i = 0; i < MO; i++) begin
            step();
            if (motor_on !== 1'b1) held = 1'b0;
        end
        check("min_on_hold", 16'(held), 16'd1);
        adc_sample("hyst_25_keep", 7'd25, 1'b1);
        adc_sample("temp_24_off", 7'd24, 1'b0);

        write_field(2'd3, 4'd1);
        do_commit("cfg_pres", 1'b1, 7'd25, 1'b0, 2'd0, 4'd0);
        adc_sample("pres_on", 7'd30, 1'b1);
        step();
        step();
        check("pres_still_on", 16'(motor_on), 16'd1);
        presence = 1'b0;
        step();
        check("pres_drop_off", 16'(motor_on), 16'd0);
        presence = 1'b1;
        step();
        step();
        step();
        check("pres_back_stay_off", 16'(motor_on), 16'd0);

        adc_sample("mode_on", 7'd30, 1'b1);
        write_field(2'd2, 4'd0);
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("mode_off_ok", 16'(cfg_ok), 16'd1);
        check("mode_off_motor", 16'(motor_on), 16'd0);
        step();

        write_field(2'd2, 4'd1);
        do_commit("cfg_auto", 1'b1, 7'd25, 1'b0, 2'd0, 4'd0);
        check("to_err_initial", 16'(timeout_err), 16'd0);
        wait_req("to_req");
        cnt = 0;
        while (adc_req && cnt < 4 * TO) begin
            cnt++;
            step();
        end
        check("to_req_cycles", 16'(cnt), 16'(TO));
        check("to_err_set", 16'(timeout_err), 16'd1);
        check("to_motor_unchanged", 16'(motor_on), 16'd0);
        push("to_clear_cfg", 16'd1);
        commit = 1'b1;
        step();
        commit = 1'b0;
        pop_check(16'(cfg_ok));
        check("to_err_cleared", 16'(timeout_err), 16'd0);
        step();

        wait_req("rst_req_req");
        rst_n = 1'b0;
        #1;
        check("rst_mid_req", all_outs(), 16'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_req_after", all_outs(), 16'd0);

        write_field(2'd0, 4'd2);
        write_field(2'd1, 4'd5);
        write_field(2'd2, 4'd1);
        do_commit("cfg_after_rst", 1'b1, 7'd25, 1'b0, 2'd0, 4'd0);
        adc_sample("rst_hold_on", 7'd30, 1'b1);
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_hold", all_outs(), 16'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < SD + 5; i++) step();
        check("rst_hold_idle", all_outs(), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/climate_sequencer.md
Name: climate_sequencer

Overview:
- Sequences the fan/motor datapath once the keypad parser has collected a configuration.
- Shadow-registers the parsed fields (tens, units, motor mode, presence mode) and validates them on commit, then promotes them to an active set.
- Runs a periodic sample/compare/drive loop: requests a temperature sample from the ADC interface, compares it with the setpoint, and drives motor_on with hysteresis and a minimum on-time.
- Sits between the keypad-parser FSM and the motor driver / sensor front-end.

Parameters:
- SAMPLE_DIV, 1000: clock cycles between sample requests (must be ≥ 2).
- ADC_TIMEOUT, 255: cycles to wait for adc_ack before abandoning a sample.
- MIN_ON, 500: minimum cycles motor_on stays high once asserted.
- HYST, 1: degrees above setpoint required to turn the motor on.

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- field_valid  in  1  one-cycle strobe: field_data is valid for field_id
- field_id  in  2  0 = tens, 1 = units, 2 = motor mode, 3 = presence mode
- field_data  in  4  field value
- commit  in  1  one-cycle strobe: validate the shadow set and promote it to the active set
- adc_data  in  7  temperature in whole degrees, binary 0..127
- adc_ack  in  1  one-cycle strobe: adc_data valid
- presence_in  in  1  occupancy sensor level
- adc_req  out  1  level; held high until adc_ack or timeout
- motor_on  out  1  motor drive
- setpoint  out  7  active setpoint, binary
- cfg_ok  out  1  one-cycle pulse: commit accepted
- cfg_err  out  1  one-cycle pulse: commit rejected
- timeout_err  out  1  sticky; cleared by the next accepted commit
- active  out  1  high once any configuration has been accepted

Behaviour:
- Reset (async assert, sync deassert by upstream):
  - Shadow and active registers = 0.
  - Outputs adc_req, motor_on, cfg_ok, cfg_err, timeout_err, active = 0; setpoint = 0.
  - State = IDLE; sample divider = 0.
- Shadow capture: on field_valid, write field_data into the shadow register selected by field_id. A later write to the same id overwrites the earlier one.
- Commit validation, decided on the commit cycle; the result pulse appears 1 cycle later:
  - Valid when tens ≤ 9, units ≤ 9, motor mode ∈ {0,1}, presence mode ∈ {0,1}.
  - Accept: active set ← shadow; setpoint ← tens*10 + units (7-bit, max 99); cfg_ok = 1; active = 1; timeout_err = 0.
  - Reject: active set unchanged; cfg_err = 1.
- Simultaneous field_valid and commit: commit validates the shadow contents before this cycle's write; the write still lands in the shadow set.
- Motor mode: 0 = forced off (motor_on = 0 regardless of temperature, MIN_ON ignored); 1 = automatic.
- Presence mode: 1 = motor may run only while presence_in = 1; 0 = presence ignored.
- Sample divider: free-running while active = 1; rolls over from SAMPLE_DIV-1 to 0 and emits an internal tick.
- FSM states: IDLE, REQ, COMPARE, HOLD.
  - IDLE: on tick → REQ, asserting adc_req in the same transition.
  - REQ: adc_req = 1.
    - adc_ack → latch adc_data, drop adc_req, go to COMPARE.
    - No ack within ADC_TIMEOUT cycles → drop adc_req, set timeout_err, go to IDLE; motor_on unchanged.
  - COMPARE (1 cycle):
    - temp ≥ setpoint+HYST (computed 8-bit, no wrap) and permitted by mode/presence → motor_on = 1, load min-on counter with MIN_ON, go to HOLD.
    - temp < setpoint, or not permitted → motor_on = 0, go to IDLE.
    - Otherwise hold motor_on, go to IDLE.
  - HOLD: count down the min-on counter; at 0 → IDLE. Ticks arriving during HOLD are dropped, not queued.
- Motor shut-off overrides: an accepted commit with motor mode 0, or presence mode 1 with presence_in = 0, forces motor_on = 0 on the next cycle from any state. If in HOLD, go to IDLE.
- A commit accepted mid-REQ does not abort the outstanding request; the new setpoint applies at the next COMPARE.

Decomposition:
- Shared package: state encoding (IDLE..HOLD), field_id constants, the BCD_MAX = 9 constant, and the mode values.
- One natural sub-module: cfg_shadow_regs, covering shadow/active registers, validation and cfg_ok/cfg_err. The FSM, divider and timers stay in the top level.

Test Plan:
- Fields 2, 5, 1, 0 then commit → cfg_ok pulse 1 cycle after commit; setpoint = 25; active = 1.
- tens = 12 then commit → cfg_err pulse; setpoint and active set unchanged.
- Setpoint 25, mode 1, adc_data 26 on ack → motor_on = 1 stays high ≥ MIN_ON cycles; a later sample of 24 → motor_on = 0 at COMPARE.
- Setpoint 25, presence mode 1, motor running, presence_in drops → motor_on = 0 the next cycle even mid-HOLD.
- adc_ack never arrives → adc_req high for exactly ADC_TIMEOUT cycles, then 0; timeout_err = 1; next accepted commit clears it.
- Reset asserted mid-REQ and mid-HOLD → all outputs 0 asynchronously; FSM in IDLE; active = 0.
